// File: rtl/cla_pkg.sv
// Shared opcode encoding and limits for the pipelined carry-lookahead adder.
package cla_pkg;

    typedef enum logic [1:0] {
        ADD = 2'd0,
        SUB = 2'd1,
        ADC = 2'd2,
        SBC = 2'd3
    } op_e;

    localparam int GROUP_MAX = 16;

endpackage

// File: rtl/cla_pipe_adder_if.sv
// Operand/result handshake bundle; master drives operands and out_ready.
interface cla_pipe_adder_if
    import cla_pkg::*;
#(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    op_e              in_op;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    modport master (
        output in_valid, in_a, in_b, in_op, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero
    );

endinterface

// File: rtl/cla_group.sv
// One GROUP-bit carry-lookahead block: every carry is a flat sum of
// generate/propagate products from the group carry-in, no ripple chain.
module cla_group #(
    parameter int GROUP = 8
) (
    input  logic [GROUP-1:0] i_a,
    input  logic [GROUP-1:0] i_b,
    input  logic             i_cin,
    output logic [GROUP-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [GROUP-1:0] w_g;
    logic [GROUP-1:0] w_p;
    logic [GROUP:0]   w_c;

    // Mask with bits [lo, hi) set; bits outside are forced to 1 before the AND-reduce.
    function automatic logic [GROUP-1:0] span(input int lo, input int hi);
        logic [GROUP-1:0] m;
        m = '0;
        for (int b = 0; b < GROUP; b++) m[b] = (b >= lo) && (b < hi);
        return m;
    endfunction

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    always_comb begin
        w_c    = '0;
        w_c[0] = i_cin;
        for (int i = 0; i < GROUP; i++) begin
            w_c[i+1] = i_cin & (&(w_p | ~span(0, i + 1)));
            for (int j = 0; j <= i; j++)
                w_c[i+1] = w_c[i+1] | (w_g[j] & (&(w_p | ~span(j + 1, i + 1))));
        end
    end

    assign o_sum  = w_p ^ w_c[GROUP-1:0];
    assign o_cout = w_c[GROUP];
    assign o_cmsb = w_c[GROUP-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined adder/subtractor: one lookahead group per stage, a single global
// advance enable, results in order with full backpressure.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int GROUP = 8
) (
    input  logic             clk,
    input  logic             rst,
    cla_pipe_adder_if.slave  bus
);

    localparam int NSTAGE = WIDTH / GROUP;

    if (GROUP < 1 || GROUP > GROUP_MAX || (WIDTH % GROUP) != 0) begin : g_param_chk
        $error("cla_pipe_adder: need 1 <= GROUP <= GROUP_MAX and WIDTH a multiple of GROUP");
    end

    logic             w_adv;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_cin0;

    always_comb begin
        w_b_eff = bus.in_b;
        w_cin0  = 1'b0;
        case (bus.in_op)
            ADD: w_cin0 = 1'b0;
            SUB: begin w_b_eff = ~bus.in_b; w_cin0 = 1'b1;       end
            ADC: w_cin0 = bus.in_cin;
            SBC: begin w_b_eff = ~bus.in_b; w_cin0 = bus.in_cin; end
            default: w_cin0 = 1'b0;
        endcase
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stg
        localparam int LO = k * GROUP;
        localparam int HI = LO + GROUP;

        // Operand bits not yet summed ride along with the partial sum.
        logic [WIDTH-1:LO] w_a_rem;
        logic [WIDTH-1:LO] w_b_rem;
        logic [HI-1:0]     w_sum_nxt;
        logic [GROUP-1:0]  w_gsum;
        logic              w_cin;
        logic              w_vin;
        logic              w_cout;
        logic [HI-1:0]     r_sum;
        logic              r_vld;
        logic              r_cout;

        if (k == 0) begin : g_src
            assign w_a_rem   = bus.in_a;
            assign w_b_rem   = w_b_eff;
            assign w_cin     = w_cin0;
            assign w_vin     = bus.in_valid;
            assign w_sum_nxt = w_gsum;
        end else begin : g_src
            assign w_a_rem   = g_stg[k-1].g_fwd.r_a;
            assign w_b_rem   = g_stg[k-1].g_fwd.r_b;
            assign w_cin     = g_stg[k-1].r_cout;
            assign w_vin     = g_stg[k-1].r_vld;
            assign w_sum_nxt = {w_gsum, g_stg[k-1].r_sum};
        end

        if (k < NSTAGE - 1) begin : g_fwd
            logic [WIDTH-1:HI] r_a;
            logic [WIDTH-1:HI] r_b;
            logic              w_cmsb_unused;

            cla_group #(.GROUP(GROUP)) u_grp (
                .i_a    (w_a_rem[LO +: GROUP]),
                .i_b    (w_b_rem[LO +: GROUP]),
                .i_cin  (w_cin),
                .o_sum  (w_gsum),
                .o_cout (w_cout),
                .o_cmsb (w_cmsb_unused)
            );

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_adv) begin
                    r_a <= w_a_rem[WIDTH-1:HI];
                    r_b <= w_b_rem[WIDTH-1:HI];
                end
            end
        end else begin : g_last
            logic w_cmsb;
            logic r_ovf;
            logic r_zero;

            cla_group #(.GROUP(GROUP)) u_grp (
                .i_a    (w_a_rem[LO +: GROUP]),
                .i_b    (w_b_rem[LO +: GROUP]),
                .i_cin  (w_cin),
                .o_sum  (w_gsum),
                .o_cout (w_cout),
                .o_cmsb (w_cmsb)
            );

            // Flags are registered alongside the sum so every output comes from a flop.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf  <= 1'b0;
                    r_zero <= 1'b0;
                end else if (w_adv) begin
                    r_ovf  <= w_cmsb ^ w_cout;
                    r_zero <= ~|w_sum_nxt;
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_vld  <= 1'b0;
                r_cout <= 1'b0;
                r_sum  <= '0;
            end else if (w_adv) begin
                r_vld  <= w_vin;
                r_cout <= w_cout;
                r_sum  <= w_sum_nxt;
            end
        end
    end

    assign w_adv         = !g_stg[NSTAGE-1].r_vld || bus.out_ready;
    assign bus.in_ready  = w_adv;
    assign bus.out_valid = g_stg[NSTAGE-1].r_vld;
    assign bus.out_sum   = g_stg[NSTAGE-1].r_sum;
    assign bus.out_cout  = g_stg[NSTAGE-1].r_cout;
    assign bus.out_ovf   = g_stg[NSTAGE-1].g_last.r_ovf;
    assign bus.out_zero  = g_stg[NSTAGE-1].g_last.r_zero;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Directed vectors on a 32/8 instance plus a randomised 16/4 instance
// checked against a behavioural add/sub model.
module tb_cla_pipe_adder;
    import cla_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cla_pipe_adder_if #(.WIDTH(32)) if32 ();
    cla_pipe_adder_if #(.WIDTH(16)) if16 ();

    cla_pipe_adder #(.WIDTH(32), .GROUP(8)) dut32 (.clk(clk), .rst(rst), .bus(if32));
    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut16 (.clk(clk), .rst(rst), .bus(if16));

    typedef struct {
        op_e         op;
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    vec_t tbl [12];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive32(input vec_t v);
        if32.in_op  = v.op;
        if32.in_a   = v.a;
        if32.in_b   = v.b;
        if32.in_cin = v.cin;
    endtask

    // Issue one op into an idle pipe and check latency and every result field.
    task automatic run32(input vec_t v, input string tag);
        int lat;
        drive32(v);
        if32.in_valid = 1'b1;
        #1;
        chk({tag, " in_ready"}, if32.in_ready, 1);
        step();
        if32.in_valid = 1'b0;
        lat = 1;
        while (!if32.out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk({tag, " latency"}, lat, 4);
        chk({tag, " sum"},  if32.out_sum,  v.sum);
        chk({tag, " cout"}, if32.out_cout, v.cout);
        chk({tag, " ovf"},  if32.out_ovf,  v.ovf);
        chk({tag, " zero"}, if32.out_zero, v.zero);
        step();
    endtask

    function automatic logic [18:0] model16(input op_e op, input logic [15:0] a,
                                            input logic [15:0] b, input logic cin);
        logic [15:0] be;
        logic        c0;
        logic [16:0] r;
        logic        ovf;
        be  = (op == SUB || op == SBC) ? ~b : b;
        c0  = (op == ADD) ? 1'b0 : (op == SUB) ? 1'b1 : cin;
        r   = {1'b0, a} + {1'b0, be} + {16'd0, c0};
        ovf = (a[15] == be[15]) && (r[15] != a[15]);
        return {r[16], ovf, r[15:0] == 16'd0, r[15:0]};
    endfunction

    initial begin
        int          got;
        int          seen;
        int          lat;
        int          acc;
        int          cyc;
        logic        held;
        logic [18:0] prev;
        logic [18:0] res;
        logic [18:0] q [$];

        tbl[0]  = '{ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[1]  = '{ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{SUB, 32'h0000_0005, 32'h0000_0007, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{ADC, 32'h0000_00FF, 32'h0000_0000, 1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{SBC, 32'h0000_0010, 32'h0000_0001, 1'b0, 32'h0000_000E, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{ADD, 32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{SUB, 32'h0000_0007, 32'h0000_0007, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{ADD, 32'h0000_FFFF, 32'h0000_0001, 1'b0, 32'h0001_0000, 1'b0, 1'b0, 1'b0};
        tbl[9]  = '{SBC, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{ADC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0};
        tbl[11] = '{ADD, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b1};

        rst = 1'b1;
        if32.in_valid = 1'b0; if32.out_ready = 1'b1; drive32(tbl[0]);
        if16.in_valid = 1'b0; if16.out_ready = 1'b1;
        if16.in_op = ADD; if16.in_a = '0; if16.in_b = '0; if16.in_cin = 1'b0;
        #12;
        chk("reset out_valid", if32.out_valid, 0);
        chk("reset out_sum",   if32.out_sum,   0);
        chk("reset out_cout",  if32.out_cout,  0);
        chk("reset out_ovf",   if32.out_ovf,   0);
        chk("reset out_zero",  if32.out_zero,  0);
        chk("reset in_ready",  if32.in_ready,  1);
        chk("reset16 out_valid", if16.out_valid, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run32(tbl[i], $sformatf("vec%0d", i));

        // Four back-to-back ops, then three cycles of backpressure.
        for (int i = 0; i < 4; i++) begin
            drive32(tbl[i]);
            if32.in_valid = 1'b1;
            #1;
            chk("b2b in_ready", if32.in_ready, 1);
            step();
        end
        if32.in_valid = 1'b0;
        chk("b2b first valid", if32.out_valid, 1);
        chk("b2b first sum", if32.out_sum, tbl[0].sum);
        if32.out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            step();
            chk("stall in_ready", if32.in_ready, 0);
            chk("stall out_valid", if32.out_valid, 1);
            chk("stall sum held", if32.out_sum, tbl[0].sum);
            chk("stall zero held", if32.out_zero, tbl[0].zero);
        end
        if32.out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (if32.out_valid) begin
                if (seen < 4) begin
                    chk($sformatf("stall order %0d sum", seen), if32.out_sum, tbl[seen].sum);
                    chk($sformatf("stall order %0d cout", seen), if32.out_cout, tbl[seen].cout);
                end
                seen++;
            end
            step();
        end
        chk("stall result count", seen, 4);

        // Reset with three ops in flight: the oldest is already at the output.
        for (int i = 0; i < 3; i++) begin
            drive32(tbl[i + 4]);
            if32.in_valid = 1'b1;
            step();
        end
        if32.in_valid = 1'b0;
        step();
        chk("pre-reset out_valid", if32.out_valid, 1);
        rst = 1'b1;
        #1;
        chk("async reset out_valid", if32.out_valid, 0);
        chk("async reset out_sum", if32.out_sum, 0);
        chk("async reset in_ready", if32.in_ready, 1);
        step();
        step();
        chk("held reset in_ready", if32.in_ready, 1);
        chk("held reset out_valid", if32.out_valid, 0);
        rst = 1'b0;
        run32(tbl[8], "post-reset");
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (if32.out_valid) seen++;
            step();
        end
        chk("post-reset ghosts", seen, 0);

        // 16-bit instance: directed latency check, then random traffic.
        if16.in_op = ADD; if16.in_a = 16'h7FFF; if16.in_b = 16'h0001; if16.in_cin = 1'b0;
        if16.in_valid = 1'b1;
        step();
        if16.in_valid = 1'b0;
        lat = 1;
        while (!if16.out_valid && lat < 20) begin
            step();
            lat++;
        end
        chk("w16 latency", lat, 4);
        chk("w16 result", {if16.out_cout, if16.out_ovf, if16.out_zero, if16.out_sum},
            {1'b0, 1'b1, 1'b0, 16'h8000});
        step();

        acc  = 0;
        cyc  = 0;
        held = 1'b0;
        prev = '0;
        while ((acc < 1000 || q.size() > 0) && cyc < 20000) begin
            if16.out_ready = ($urandom_range(0, 3) != 0);
            if (acc < 1000 && $urandom_range(0, 3) != 0) begin
                if16.in_valid = 1'b1;
                if16.in_op    = op_e'($urandom_range(0, 3));
                if16.in_a     = 16'($urandom);
                if16.in_b     = 16'($urandom);
                if16.in_cin   = 1'($urandom_range(0, 1));
            end else begin
                if16.in_valid = 1'b0;
            end
            #1;
            res = {if16.out_cout, if16.out_ovf, if16.out_zero, if16.out_sum};
            if (held) begin
                chk("rand held valid", if16.out_valid, 1);
                chk("rand held data", res, prev);
            end
            held = 1'b0;
            if (if16.out_valid) begin
                if (if16.out_ready) begin
                    chk("rand result available", q.size() != 0, 1);
                    if (q.size() != 0) chk("rand result", res, q.pop_front());
                end else begin
                    held = 1'b1;
                    prev = res;
                end
            end
            if (if16.in_valid && if16.in_ready) begin
                q.push_back(model16(if16.in_op, if16.in_a, if16.in_b, if16.in_cin));
                acc++;
            end
            step();
            cyc++;
        end
        if16.in_valid = 1'b0;
        chk("rand accepted", acc, 1000);
        chk("rand drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
CLA_PIPE_ADDER -- requirements
Module: cla_pipe_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width in bits.
REQ-002 SHALL have parameter GROUP, default 8, lookahead group width; WIDTH % GROUP == 0 and 1 <= GROUP <= 16, else elaboration error.
REQ-003 SHALL derive localparam NSTAGE = WIDTH/GROUP, the pipeline depth.
REQ-004 clk  in  1  single clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  operand set present.
REQ-007 in_ready  out  1  block accepts operand set this cycle.
REQ-008 in_a  in  WIDTH  operand A.
REQ-009 in_b  in  WIDTH  operand B.
REQ-010 in_op  in  2  opcode, op_e: ADD=0, SUB=1, ADC=2, SBC=3.
REQ-011 in_cin  in  1  carry input, used by ADC/SBC only.
REQ-012 out_valid  out  1  result present.
REQ-013 out_ready  in  1  consumer takes result this cycle.
REQ-014 out_sum  out  WIDTH  result.
REQ-015 out_cout  out  1  carry out of bit WIDTH-1.
REQ-016 out_ovf  out  1  signed (two's-complement) overflow.
REQ-017 out_zero  out  1  out_sum == 0.

Function
REQ-018 Effective B SHALL be in_b for ADD/ADC, ~in_b for SUB/SBC; carry-in SHALL be 0 (ADD), 1 (SUB), in_cin (ADC, SBC).
REQ-019 Result SHALL equal {cout,sum} = A + B_eff + cin, modulo 2^(WIDTH+1); for SUB/SBC cout=1 means no borrow.
REQ-020 Stage k (0..NSTAGE-1) SHALL compute group k bits [k*GROUP +: GROUP] with full two-level lookahead (per-bit generate/propagate, all group carries from incoming carry, no ripple), registering group sum, group carry-out and remaining upper operand bits.
REQ-021 out_ovf SHALL be carry-into-MSB XOR carry-out-of-MSB; out_zero SHALL be computed from the final registered sum.
REQ-022 Transfer on input SHALL occur when in_valid && in_ready; on output when out_valid && out_ready.
REQ-023 Global advance enable SHALL be adv = !out_valid || out_ready; in_ready SHALL equal adv (combinational, no dependence on in_valid).
REQ-024 Each stage SHALL carry a valid bit; when adv=1 every stage loads from its predecessor (stage 0 from the input, valid = in_valid); when adv=0 all stages hold.
REQ-025 Latency SHALL be NSTAGE cycles without stall: accepted at edge n, out_valid=1 after edge n+NSTAGE-1.
REQ-026 Throughput SHALL be one result per cycle with out_ready held high; no bubble insertion.
REQ-027 Results SHALL emerge in acceptance order; no loss or duplication under any out_ready pattern.
REQ-028 While out_valid=1 and out_ready=0, out_sum/out_cout/out_ovf/out_zero SHALL be stable.
REQ-029 Invalid stages SHALL still load when adv=1; their data is don't-care but outputs SHALL be driven from registers only.

Reset
REQ-030 rst=1 SHALL immediately clear all stage valid bits; out_valid=0, out_sum=0, out_cout=0, out_ovf=0, out_zero=0.
REQ-031 Reset mid-operation SHALL discard all in-flight transactions; in_ready=1 during and after reset.
REQ-032 First acceptance SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-033 Package cla_pkg SHALL hold op_e enum and GROUP_MAX=16 constant.
REQ-034 Sub-module cla_group SHALL implement one GROUP-bit lookahead group (inputs a, b, cin; outputs sum, cout, carry-into-MSB), instantiated NSTAGE times via generate.
REQ-035 No other sub-modules; pipeline registers live in cla_pipe_adder.

Verification (WIDTH=32, GROUP=8 unless stated)
REQ-036 ADD 0xFFFFFFFF+0x00000001, out_ready=1 -> after 4 edges sum=0x00000000, cout=1, zero=1, ovf=0.
REQ-037 ADD 0x7FFFFFFF+0x00000001 -> sum=0x80000000, cout=0, ovf=1, zero=0; SUB 5-7 -> sum=0xFFFFFFFE, cout=0, ovf=0.
REQ-038 ADC 0x000000FF+0x00000000 cin=1 -> sum=0x00000100, cout=0; SBC 0x10-0x01 cin=0 -> sum=0x0000000E, cout=1.
REQ-039 4 back-to-back ops, out_ready low 3 cycles after first out_valid -> in_ready=0 while stalled, all 4 results in order, values held.
REQ-040 rst pulse with 3 transactions in flight -> out_valid=0 immediately, none emerge; next op after reset correct with latency 4.
REQ-041 WIDTH=16, GROUP=4: 1000 random ops vs reference model, random out_ready -> zero mismatches, latency 4.
